// File: rtl/alu_ex_stage_if.sv
// Bus bundle for the execute stage: upstream decode inputs, ALU drive/return
// signals and the downstream EX/MEM output register.
interface alu_ex_stage_if #(
  parameter int TRAP_CNT_W = 16
);
  // upstream side
  logic                  InValid;
  logic                  InReady;
  logic [1:0]            AluOpSel;
  logic [5:0]            Funct;
  logic                  AluSrc;
  logic                  TrapEn;
  logic [31:0]           Rs;
  logic [31:0]           Rt;
  logic [15:0]           Imm;
  logic [4:0]            DestReg;
  logic                  RegWrite;
  logic                  Flush;
  // ALU side
  logic [3:0]            AluControl;
  logic [31:0]           AluOperand1;
  logic [31:0]           AluOperand2;
  logic [31:0]           AluResult;
  logic                  AluZero;
  logic                  AluOverflow;
  // downstream side
  logic                  OutValid;
  logic                  OutReady;
  logic [31:0]           OutResult;
  logic                  OutZero;
  logic                  OutCarry;
  logic                  OutTrap;
  logic                  OutIllegal;
  logic                  OutRegWrite;
  logic [4:0]            OutDestReg;
  logic [TRAP_CNT_W-1:0] TrapCount;

  // execute stage view
  modport slave (
    input  InValid, AluOpSel, Funct, AluSrc, TrapEn, Rs, Rt, Imm, DestReg,
           RegWrite, Flush, AluResult, AluZero, AluOverflow, OutReady,
    output InReady, AluControl, AluOperand1, AluOperand2, OutValid, OutResult,
           OutZero, OutCarry, OutTrap, OutIllegal, OutRegWrite, OutDestReg,
           TrapCount
  );

  // environment view (decode stage, ALU and memory stage together)
  modport master (
    output InValid, AluOpSel, Funct, AluSrc, TrapEn, Rs, Rt, Imm, DestReg,
           RegWrite, Flush, AluResult, AluZero, AluOverflow, OutReady,
    input  InReady, AluControl, AluOperand1, AluOperand2, OutValid, OutResult,
           OutZero, OutCarry, OutTrap, OutIllegal, OutRegWrite, OutDestReg,
           TrapCount
  );
endinterface

// File: rtl/alu_ex_stage.sv
// Execute-stage controller: decodes the ALU control code, drives the ALU
// operands combinationally, and captures result/flags/trap status into a
// one-entry EX/MEM register with valid/ready handshakes on both sides.
module alu_ex_stage #(
  parameter int TRAP_CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  alu_ex_stage_if.slave bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic [3:0]            ctrl;
  logic                  illegal;
  logic [31:0]           op1, op2;
  logic                  ovf, trap, load, in_ready;

  logic [31:0]           result_reg;
  logic [4:0]            dest_reg;
  logic                  zero_reg, carry_reg, trap_reg, illegal_reg, regwrite_reg;
  logic [TRAP_CNT_W-1:0] trap_cnt_reg;

  assign op1 = bus.Rs;
  assign op2 = bus.AluSrc ? {{16{bus.Imm[15]}}, bus.Imm} : bus.Rt;

  // Translate the decoded op class (and Funct for R-type) into the ALU code.
  always_comb begin
    ctrl    = 4'd0;
    illegal = 1'b0;
    case (bus.AluOpSel)
      2'b00: ctrl = 4'd0;
      2'b01: ctrl = 4'd1;
      2'b11: ctrl = 4'd7;
      default: begin
        case (bus.Funct)
          6'b100000: ctrl = 4'd0;
          6'b100010: ctrl = 4'd1;
          6'b100100: ctrl = 4'd2;
          6'b100101: ctrl = 4'd3;
          6'b100110: ctrl = 4'd4;
          6'b101010: ctrl = 4'd5;
          default: begin
            ctrl    = 4'd15;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Signed overflow from operand/result signs; the ALU's bit 32 is carry only.
  always_comb begin
    ovf = 1'b0;
    case (ctrl)
      4'd0: ovf = (op1[31] == op2[31]) && (bus.AluResult[31] != op1[31]);
      4'd1: ovf = (op1[31] != op2[31]) && (bus.AluResult[31] != op1[31]);
      default: ovf = 1'b0;
    endcase
  end

  assign trap     = bus.TrapEn && ovf;
  assign in_ready = (state_reg == EMPTY) || bus.OutReady;
  assign load     = bus.InValid && in_ready && !bus.Flush;

  // Next-state logic; Flush empties the register regardless of traffic.
  always_comb begin
    state_next = state_reg;
    if (bus.Flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: if (load) state_next = FULL;
        FULL: begin
          if (load)              state_next = FULL;
          else if (bus.OutReady) state_next = EMPTY;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= EMPTY;
    else       state_reg <= state_next;
  end

  // Payload capture; only a load touches it, so drained entries stay stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_reg   <= '0;
      dest_reg     <= '0;
      zero_reg     <= 1'b0;
      carry_reg    <= 1'b0;
      trap_reg     <= 1'b0;
      illegal_reg  <= 1'b0;
      regwrite_reg <= 1'b0;
    end else if (load) begin
      result_reg   <= bus.AluResult;
      dest_reg     <= bus.DestReg;
      zero_reg     <= bus.AluZero;
      carry_reg    <= bus.AluOverflow;
      trap_reg     <= trap;
      illegal_reg  <= illegal;
      regwrite_reg <= bus.RegWrite && !trap && !illegal;
    end
  end

  // Saturating count of accepted operations that trapped.
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_cnt_reg <= '0;
    end else if (load && trap && (trap_cnt_reg != {TRAP_CNT_W{1'b1}})) begin
      trap_cnt_reg <= trap_cnt_reg + TRAP_CNT_W'(1);
    end
  end

  assign bus.InReady     = in_ready;
  assign bus.AluControl  = ctrl;
  assign bus.AluOperand1 = op1;
  assign bus.AluOperand2 = op2;
  assign bus.OutValid    = (state_reg == FULL);
  assign bus.OutResult   = result_reg;
  assign bus.OutZero     = zero_reg;
  assign bus.OutCarry    = carry_reg;
  assign bus.OutTrap     = trap_reg;
  assign bus.OutIllegal  = illegal_reg;
  assign bus.OutRegWrite = regwrite_reg;
  assign bus.OutDestReg  = dest_reg;
  assign bus.TrapCount   = trap_cnt_reg;
endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage with a behavioural 33-bit SubALU model.
module tb_alu_ex_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_ex_stage_if #(.TRAP_CNT_W(16)) bus ();

  alu_ex_stage #(.TRAP_CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // SubALU model: 33-bit result, bit 32 is carry/borrow.
  logic [32:0] alu33;
  always_comb begin
    alu33 = '0;
    case (bus.AluControl)
      4'd0: alu33 = {1'b0, bus.AluOperand1} + {1'b0, bus.AluOperand2};
      4'd1: alu33 = {1'b0, bus.AluOperand1} - {1'b0, bus.AluOperand2};
      4'd2: alu33 = {1'b0, bus.AluOperand1 & bus.AluOperand2};
      4'd3: alu33 = {1'b0, bus.AluOperand1 | bus.AluOperand2};
      4'd4: alu33 = {1'b0, bus.AluOperand1 ^ bus.AluOperand2};
      4'd5: alu33 = {32'd0, bus.AluOperand1 < bus.AluOperand2};
      4'd7: alu33 = {32'd0, bus.AluOperand1 == bus.AluOperand2};
      default: alu33 = '0;
    endcase
  end
  assign bus.AluResult   = alu33[31:0];
  assign bus.AluZero     = (alu33[31:0] == 32'd0);
  assign bus.AluOverflow = alu33[32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic set_op(input logic [1:0] sel, input logic [5:0] funct, input logic src,
                        input logic trap_en, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [15:0] imm, input logic [4:0] dest, input logic regwrite);
    bus.AluOpSel = sel;
    bus.Funct    = funct;
    bus.AluSrc   = src;
    bus.TrapEn   = trap_en;
    bus.Rs       = rs;
    bus.Rt       = rt;
    bus.Imm      = imm;
    bus.DestReg  = dest;
    bus.RegWrite = regwrite;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Table of back-to-back R-type/EQ vectors.
  logic [1:0]  tv_sel   [4];
  logic [5:0]  tv_funct [4];
  logic [31:0] tv_rs    [4];
  logic [31:0] tv_rt    [4];
  logic [3:0]  tv_ctrl  [4];
  logic [31:0] tv_res   [4];

  initial begin
    tv_sel[0] = 2'b10; tv_funct[0] = 6'b100101; tv_rs[0] = 32'hF000_0000; tv_rt[0] = 32'h0000_000F; tv_ctrl[0] = 4'd3; tv_res[0] = 32'hF000_000F;
    tv_sel[1] = 2'b10; tv_funct[1] = 6'b100110; tv_rs[1] = 32'hFF00_FF00; tv_rt[1] = 32'h0FF0_0FF0; tv_ctrl[1] = 4'd4; tv_res[1] = 32'hF0F0_F0F0;
    tv_sel[2] = 2'b10; tv_funct[2] = 6'b101010; tv_rs[2] = 32'h0000_0001; tv_rt[2] = 32'hFFFF_FFFF; tv_ctrl[2] = 4'd5; tv_res[2] = 32'h0000_0001;
    tv_sel[3] = 2'b11; tv_funct[3] = 6'b000000; tv_rs[3] = 32'h0000_0009; tv_rt[3] = 32'h0000_0009; tv_ctrl[3] = 4'd7; tv_res[3] = 32'h0000_0001;

    reset = 1'b1;
    bus.InValid = 1'b1; bus.Flush = 1'b0; bus.OutReady = 1'b1;
    set_op(2'b10, 6'b100000, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'd1, 16'd0, 5'd5, 1'b1);

    // Reset with InValid asserted.
    step(); step();
    check("rst_valid", 32'(bus.OutValid), 32'd0);
    check("rst_trapcnt", 32'(bus.TrapCount), 32'd0);
    check("rst_result", bus.OutResult, 32'd0);
    check("rst_flags", {25'd0, bus.OutZero, bus.OutCarry, bus.OutTrap, bus.OutIllegal, bus.OutRegWrite, 2'd0}, 32'd0);
    check("rst_dest", 32'(bus.OutDestReg), 32'd0);
    reset = 1'b0;

    // R-type ADD with signed overflow and trap enabled.
    #1;
    check("add_ctrl", 32'(bus.AluControl), 32'd0);
    check("add_op2", bus.AluOperand2, 32'd1);
    step();
    check("add_valid", 32'(bus.OutValid), 32'd1);
    check("add_result", bus.OutResult, 32'h8000_0000);
    check("add_trap", 32'(bus.OutTrap), 32'd1);
    check("add_regwrite", 32'(bus.OutRegWrite), 32'd0);
    check("add_trapcnt", 32'(bus.TrapCount), 32'd1);
    check("add_dest", 32'(bus.OutDestReg), 32'd5);
    $display("txn ADD  result=%h trap=%0d cnt=%0d", bus.OutResult, bus.OutTrap, bus.TrapCount);

    // Immediate ADD with carry-out, negative immediate sign extension check.
    set_op(2'b00, 6'b000000, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 16'hFFFF, 5'd6, 1'b1);
    #1;
    check("imm_sext", bus.AluOperand2, 32'hFFFF_FFFF);
    bus.Imm = 16'h0001;
    #1;
    check("imm_op2", bus.AluOperand2, 32'h0000_0001);
    step();
    check("imm_result", bus.OutResult, 32'd0);
    check("imm_zero", 32'(bus.OutZero), 32'd1);
    check("imm_carry", 32'(bus.OutCarry), 32'd1);
    check("imm_trap", 32'(bus.OutTrap), 32'd0);
    check("imm_regwrite", 32'(bus.OutRegWrite), 32'd1);
    check("imm_trapcnt", 32'(bus.TrapCount), 32'd1);
    $display("txn ADDI result=%h zero=%0d carry=%0d", bus.OutResult, bus.OutZero, bus.OutCarry);

    // Drain, then SUB 5-7 under backpressure.
    bus.InValid = 1'b0;
    step();
    check("drain_valid", 32'(bus.OutValid), 32'd0);
    check("drain_stale", bus.OutResult, 32'd0);
    bus.InValid = 1'b1; bus.OutReady = 1'b0;
    set_op(2'b01, 6'b000000, 1'b0, 1'b1, 32'd5, 32'd7, 16'd0, 5'd7, 1'b1);
    #1;
    check("sub_ctrl", 32'(bus.AluControl), 32'd1);
    step();
    set_op(2'b10, 6'b100100, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 16'd0, 5'd8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(bus.OutValid), 32'd1);
      check("bp_result", bus.OutResult, 32'hFFFF_FFFE);
      check("bp_inready", 32'(bus.InReady), 32'd0);
      check("bp_dest", 32'(bus.OutDestReg), 32'd7);
      $display("txn SUB hold %0d result=%h inready=%0d", i, bus.OutResult, bus.InReady);
      if (i < 2) step();
    end
    check("sub_carry", 32'(bus.OutCarry), 32'd1);
    check("sub_trap", 32'(bus.OutTrap), 32'd0);
    bus.OutReady = 1'b1;
    #1;
    check("bp_release", 32'(bus.InReady), 32'd1);
    step();
    check("and_result", bus.OutResult, 32'h0000_00F0);
    check("and_dest", 32'(bus.OutDestReg), 32'd8);
    $display("txn AND  result=%h", bus.OutResult);

    // Back-to-back table at full throughput.
    for (int i = 0; i < 4; i++) begin
      set_op(tv_sel[i], tv_funct[i], 1'b0, 1'b0, tv_rs[i], tv_rt[i], 16'd0, 5'(i + 10), 1'b1);
      #1;
      check("tbl_ctrl", 32'(bus.AluControl), 32'(tv_ctrl[i]));
      step();
      check("tbl_valid", 32'(bus.OutValid), 32'd1);
      check("tbl_result", bus.OutResult, tv_res[i]);
      $display("txn TBL%0d ctrl=%0d result=%h", i, tv_ctrl[i], bus.OutResult);
    end

    // Illegal Funct.
    set_op(2'b10, 6'b111111, 1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111, 16'd0, 5'd3, 1'b1);
    #1;
    check("ill_ctrl", 32'(bus.AluControl), 32'd15);
    step();
    check("ill_flag", 32'(bus.OutIllegal), 32'd1);
    check("ill_result", bus.OutResult, 32'd0);
    check("ill_regwrite", 32'(bus.OutRegWrite), 32'd0);
    $display("txn ILL  illegal=%0d result=%h", bus.OutIllegal, bus.OutResult);

    // Flush while FULL with a trapping incoming Load.
    set_op(2'b10, 6'b100000, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'd1, 16'd0, 5'd9, 1'b1);
    bus.Flush = 1'b1;
    #1;
    check("flush_inready", 32'(bus.InReady), 32'd1);
    step();
    check("flush_valid", 32'(bus.OutValid), 32'd0);
    check("flush_trapcnt", 32'(bus.TrapCount), 32'd1);
    $display("txn FLUSH valid=%0d cnt=%0d", bus.OutValid, bus.TrapCount);
    bus.Flush = 1'b0;

    // Saturation: 65534 more trapping loads bring the count to 0xFFFF.
    repeat (65534) step();
    check("sat_reach", 32'(bus.TrapCount), 32'h0000_FFFF);
    repeat (3) step();
    check("sat_hold", 32'(bus.TrapCount), 32'h0000_FFFF);
    $display("txn SAT  cnt=%h", bus.TrapCount);

    // Reset while FULL discards the entry.
    check("pre_rst_valid", 32'(bus.OutValid), 32'd1);
    reset = 1'b1; bus.InValid = 1'b0;
    step();
    reset = 1'b0;
    check("midrst_valid", 32'(bus.OutValid), 32'd0);
    check("midrst_trapcnt", 32'(bus.TrapCount), 32'd0);
    check("midrst_result", bus.OutResult, 32'd0);
    $display("txn RST  valid=%0d cnt=%0d", bus.OutValid, bus.TrapCount);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_ex_stage.md
# alu_ex_stage

Execute-stage controller for the MIPS datapath. It sits between the ID/EX decode outputs and the 32-bit SubALU. It translates the decoded operation into the 4-bit ALU control code, selects the operands, and drives the ALU combinationally. It then captures the ALU result, flags and trap status into a one-entry EX/MEM output register with valid/ready handshakes on both sides.

## Interface
Parameters:
- TRAP_CNT_W, 16, width of the saturating overflow-trap counter

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- InValid  in  1  upstream operation valid
- InReady  out  1  stage can accept an operation this cycle
- AluOpSel  in  2  00 ADD (load/store), 01 SUB (branch), 10 R-type by Funct, 11 EQ compare
- Funct  in  6  R-type function field
- AluSrc  in  1  0: operand 2 = Rt, 1: operand 2 = sign-extended Imm
- TrapEn  in  1  enable signed-overflow trap for this operation
- Rs, Rt  in  32  register operands
- Imm  in  16  immediate
- DestReg  in  5  destination register, passed through
- RegWrite  in  1  write enable, passed through
- Flush  in  1  kill the held and incoming operation
- AluControl  out  4  to the ALU control input
- AluOperand1, AluOperand2  out  32  to the ALU operands
- AluResult  in  32  from the ALU
- AluZero, AluOverflow  in  1  from the ALU (AluOverflow is bit 32 of the 33-bit result, i.e. carry/borrow)
- OutValid  out  1  output register holds a valid entry
- OutReady  in  1  downstream accepts
- OutResult  out  32; OutZero, OutCarry, OutTrap, OutIllegal, OutRegWrite  out  1; OutDestReg  out  5
- TrapCount  out  TRAP_CNT_W  number of trapped operations

## Operation
- Control mapping:
  - AluOpSel 00 → 0 (ADD).
  - AluOpSel 01 → 1 (SUB).
  - AluOpSel 11 → 7 (EQ).
  - AluOpSel 10 uses Funct: 100000→0, 100010→1, 100100→2 (AND), 100101→3 (OR), 100110→4 (XOR), 101010→5 (SLT, unsigned compare).
  - Any other Funct → code 15 with Illegal=1. The ALU returns 0 for code 15.
  - Code 6 is never issued.
- AluOperand1 = Rs.
- AluOperand2 = AluSrc ? {{16{Imm[15]}}, Imm} : Rt.
- All Alu* outputs are purely combinational from the current inputs.
- Signed overflow is computed in this block from the operands, not taken from AluOverflow:
  - ADD: Ovf = (op1[31]==op2[31]) && (AluResult[31]!=op1[31]).
  - SUB: Ovf = (op1[31]!=op2[31]) && (AluResult[31]!=op1[31]).
  - Ovf = 0 for all other codes.
- Trap = TrapEn && Ovf.
- OutRegWrite = RegWrite && !Trap && !Illegal.
- OutCarry = AluOverflow as captured.
- State machine, 2 states:
  - EMPTY: OutValid=0.
  - FULL: OutValid=1.
  - Load = InValid && InReady && !Flush.
  - EMPTY → FULL on Load.
  - FULL → EMPTY on OutReady && !Load.
  - FULL → FULL on Load (back-to-back replace) or on !OutReady (hold).
  - Flush forces EMPTY next cycle from either state and suppresses Load.
- InReady = !OutValid || OutReady. It is combinational and independent of Flush.
- Held output fields are stable while FULL && !OutReady.
- TrapCount increments by 1 on each Load with Trap=1 and saturates at all-ones. Flush does not decrement it.

## Timing
- Latency 1 cycle: an operation accepted at edge N appears on Out* with OutValid=1 after edge N. It transfers on the first edge where OutReady=1.
- Throughput 1 operation/cycle when OutReady is held high.
- Reset (synchronous, highest priority):
  - State EMPTY.
  - OutValid=0.
  - OutResult=0, OutDestReg=0.
  - OutZero, OutCarry, OutTrap, OutIllegal, OutRegWrite all 0.
  - TrapCount=0.
  - Reset mid-FULL discards the entry.
- Flush and Load in the same cycle: the register is invalidated and the incoming operation is lost.
- Flush with OutReady=1 in FULL: the downstream transfer still counts on that edge, so the consumer must qualify it with its own flush.
- Out* payload registers update only on Load. After a drain they keep stale values with OutValid=0.

## Test plan
- Reset: assert reset for 2 cycles with InValid=1 → OutValid=0, TrapCount=0, all outputs 0.
- R-type ADD: Rs=0x7FFFFFFF, Rt=1, Funct=100000, TrapEn=1, RegWrite=1, OutReady=1.
  - Same cycle: AluControl=0.
  - Next cycle: OutResult=0x80000000, OutTrap=1, OutRegWrite=0, TrapCount=1.
- Immediate and carry: AluOpSel=00, AluSrc=1, Rs=0xFFFFFFFF, Imm=0x0001 → OutResult=0, OutZero=1, OutCarry=1, OutTrap=0.
- Backpressure: issue SUB 5−7 with OutReady=0 for 3 cycles.
  - OutResult=0xFFFFFFFE stays stable and InReady=0.
  - Raise OutReady: back-to-back issue of AND 0xF0F0 & 0x0FF0 yields 0x00F0 on the next cycle.
- Illegal Funct: Funct=111111 → AluControl=15, OutIllegal=1, OutResult=0, OutRegWrite=0.
- Flush: Flush=1 while FULL with an incoming Load → OutValid=0 next cycle and TrapCount unchanged. Saturation check: preload 0xFFFF trap events → TrapCount stays 0xFFFF.
